vc_test_sink_checker: RTL and testbench

//  Test-harness consumer placed directly downstream of the random-delay stage (out_val/out_rdy/out_msg).

---
 rtl/vc_test_sink_pkg.sv | 10 +
 rtl/vc_test_sink_checker_if.sv | 11 +
 rtl/vc_test_sink_mem.sv | 24 ++
 rtl/vc_test_sink_checker.sv | 125 ++++++++++++
 tb/tb_vc_test_sink_checker.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vc_test_sink_pkg.sv
// Shared types and constants for the expected-message sink checker.
// Optional masking is enabled by VC_TEST_SINK_CHECKER_MASK_EN.
package vc_test_sink_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int C_ERR_CNT_NBITS = 32;
   localparam logic [C_ERR_CNT_NBITS-1:0] C_ERR_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/vc_test_sink_checker_if.sv
// val/rdy message channel between the random-delay stage and the sink checker.
interface vc_test_sink_checker_if #(parameter int p_msg_nbits = 8);

   logic                   in_val;
   logic                   in_rdy;
   logic [p_msg_nbits-1:0] in_msg;

   modport master (output in_val, output in_msg, input in_rdy);
   modport slave  (input in_val, input in_msg, output in_rdy);

endinterface

// File: rtl/vc_test_sink_mem.sv
// Expected-entry table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a table survives a mid-run abort.
module vc_test_sink_mem #(
   parameter int p_width = 8,
   parameter int p_depth = 1024,
   localparam int c_addr_nbits = $clog2(p_depth)
) (
   input  logic                    clk,
   input  logic                    wr_en,
   input  logic [c_addr_nbits-1:0] wr_addr,
   input  logic [p_width-1:0]      wr_data,
   input  logic [c_addr_nbits-1:0] rd_addr,
   output logic [p_width-1:0]      rd_data
);

   logic [p_width-1:0] mem [p_depth];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vc_test_sink_checker.sv
// In-order expected-message checker on a val/rdy channel; counts mismatches and overflow.
// Define VC_TEST_SINK_CHECKER_MASK_EN to add per-entry don't-care masks (ld_mask port).
module vc_test_sink_checker
   import vc_test_sink_pkg::*;
#(
   parameter int p_msg_nbits = 8,
   parameter int p_num_msgs  = 1024,
   localparam int c_idx_nbits = $clog2(p_num_msgs),
   localparam int c_cnt_nbits = c_idx_nbits + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ld_en,
   input  logic [c_idx_nbits-1:0]     ld_addr,
   input  logic [p_msg_nbits-1:0]     ld_msg,
`ifdef VC_TEST_SINK_CHECKER_MASK_EN
   input  logic [p_msg_nbits-1:0]     ld_mask,
`endif
   input  logic [c_cnt_nbits-1:0]     num_msgs,
   input  logic                       start,
   vc_test_sink_checker_if.slave      sink,
   output logic                       done,
   output logic [C_ERR_CNT_NBITS-1:0] num_errors,
   output logic                       first_err_val,
   output logic [c_cnt_nbits-1:0]     first_err_idx
);

`ifdef VC_TEST_SINK_CHECKER_MASK_EN
   localparam int c_w = 2 * p_msg_nbits;
`else
   localparam int c_w = p_msg_nbits;
`endif

   state_t                 state;
   logic [c_idx_nbits-1:0] idx;
   logic [c_cnt_nbits-1:0] count;
   logic [c_cnt_nbits-1:0] num_clamped;
   logic [c_cnt_nbits-1:0] err_at;
   logic [c_w-1:0]         wr_data;
   logic [c_w-1:0]         rd_data;
   logic                   xfer;
   logic                   mismatch;
   logic                   arm;
   logic                   err;
   logic                   last;

   assign sink.in_rdy = (state != IDLE);
   assign done        = (state == DONE);
   assign xfer        = sink.in_val && sink.in_rdy;
   assign num_clamped = (num_msgs > c_cnt_nbits'(p_num_msgs)) ? c_cnt_nbits'(p_num_msgs) : num_msgs;
   assign last        = (c_cnt_nbits'(idx) == count - 1'b1);

`ifdef VC_TEST_SINK_CHECKER_MASK_EN
   // Entry layout is {mask, msg}; a set mask bit excludes that bit from the compare.
   assign wr_data  = {ld_mask, ld_msg};
   assign mismatch = |((sink.in_msg ^ rd_data[p_msg_nbits-1:0]) & ~rd_data[c_w-1:p_msg_nbits]);
`else
   assign wr_data  = ld_msg;
   assign mismatch = (sink.in_msg != rd_data);
`endif

   vc_test_sink_mem #(.p_width(c_w), .p_depth(p_num_msgs)) u_mem (
      .clk     (clk),
      .wr_en   (ld_en && (state != RUN)),
      .wr_addr (ld_addr),
      .wr_data (wr_data),
      .rd_addr (idx),
      .rd_data (rd_data)
   );

   // Overflow transfers in DONE are logged at index count.
   always_comb begin
      arm    = start && (state != RUN);
      err    = 1'b0;
      err_at = count;
      if (state == RUN && xfer && mismatch) begin
         err    = 1'b1;
         err_at = c_cnt_nbits'(idx);
      end else if (state == DONE && xfer) begin
         err = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         idx           <= '0;
         count         <= '0;
         num_errors    <= '0;
         first_err_val <= 1'b0;
         first_err_idx <= '0;
      end else if (arm) begin
         state         <= (num_clamped == '0) ? DONE : RUN;
         idx           <= '0;
         count         <= num_clamped;
         num_errors    <= '0;
         first_err_val <= 1'b0;
         first_err_idx <= '0;
      end else begin
         if (err) begin
            if (num_errors != C_ERR_SAT) num_errors <= num_errors + 1'b1;
            if (!first_err_val) begin
               first_err_val <= 1'b1;
               first_err_idx <= err_at;
            end
         end
         if (state == RUN && xfer) begin
            idx <= idx + 1'b1;
            if (last) state <= DONE;
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && state != IDLE) begin
         vc_assert_not_x_val: assert (!$isunknown(sink.in_val));
         if (xfer) begin
            vc_assert_not_x_msg: assert (!$isunknown(sink.in_msg));
         end
      end
   end
`endif

endmodule

// File: tb/tb_vc_test_sink_checker.sv
// Directed bench for vc_test_sink_checker; mask cases run when VC_TEST_SINK_CHECKER_MASK_EN is defined.
module tb_vc_test_sink_checker;

   localparam int MB = 8;
   localparam int NM = 1024;
   localparam int IW = $clog2(NM);

   logic          clk = 1'b0;
   logic          reset;
   logic          ld_en;
   logic [IW-1:0] ld_addr;
   logic [MB-1:0] ld_msg;
`ifdef VC_TEST_SINK_CHECKER_MASK_EN
   logic [MB-1:0] ld_mask;
`endif
   logic [IW:0]   num_msgs;
   logic          start;
   logic          done;
   logic [31:0]   num_errors;
   logic          first_err_val;
   logic [IW:0]   first_err_idx;

   int n_cmp = 0;
   int n_bad = 0;

   vc_test_sink_checker_if #(.p_msg_nbits(MB)) sink ();

   vc_test_sink_checker #(.p_msg_nbits(MB), .p_num_msgs(NM)) dut (
      .clk           (clk),
      .reset         (reset),
      .ld_en         (ld_en),
      .ld_addr       (ld_addr),
      .ld_msg        (ld_msg),
`ifdef VC_TEST_SINK_CHECKER_MASK_EN
      .ld_mask       (ld_mask),
`endif
      .num_msgs      (num_msgs),
      .start         (start),
      .sink          (sink),
      .done          (done),
      .num_errors    (num_errors),
      .first_err_val (first_err_val),
      .first_err_idx (first_err_idx)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [IW-1:0] a, input logic [MB-1:0] m);
      ld_en = 1'b1; ld_addr = a; ld_msg = m;
      step();
      ld_en = 1'b0;
   endtask

   task automatic do_start(input logic [IW:0] n);
      num_msgs = n; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Drives one message after gap idle cycles; in_val stays high unless last is set.
   task automatic send(input logic [MB-1:0] m, input int gap, input bit last);
      if (gap > 0) begin
         sink.in_val = 1'b0;
         repeat (gap) step();
      end
      sink.in_val = 1'b1;
      sink.in_msg = m;
      for (int k = 0; k < 20 && !sink.in_rdy; k++) step();
      n_cmp++;
      if (sink.in_rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL send_timeout: in_rdy=%b required 1", sink.in_rdy);
      end
      step();
      if (last) sink.in_val = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      step();
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_rdy", 32'(sink.in_rdy), 32'd0);
      chk("reset_errs", num_errors, 32'd0);
      chk("reset_fev", 32'(first_err_val), 32'd0);
      chk("reset_fei", 32'(first_err_idx), 32'd0);
   endtask

   task automatic test_back_to_back();
      load(0, 8'h11); load(1, 8'h22); load(2, 8'h33);
      do_start(3);
      chk("b2b_rdy", 32'(sink.in_rdy), 32'd1);
      chk("b2b_done0", 32'(done), 32'd0);
      send(8'h11, 0, 0);
      send(8'h22, 0, 0);
      chk("b2b_done2", 32'(done), 32'd0);
      send(8'h33, 0, 1);
      chk("b2b_done3", 32'(done), 32'd1);
      chk("b2b_errs", num_errors, 32'd0);
      chk("b2b_fev", 32'(first_err_val), 32'd0);
   endtask

   task automatic test_mismatch_delay();
      do_start(3);
      send(8'h11, 2, 1);
      send(8'h2F, 5, 1);
      send(8'h33, 3, 1);
      chk("mm_errs", num_errors, 32'd1);
      chk("mm_fev", 32'(first_err_val), 32'd1);
      chk("mm_fei", 32'(first_err_idx), 32'd1);
      chk("mm_done", 32'(done), 32'd1);
   endtask

   task automatic test_zero_count();
      do_start(0);
      chk("zc_done", 32'(done), 32'd1);
      chk("zc_rdy", 32'(sink.in_rdy), 32'd1);
      chk("zc_errs0", num_errors, 32'd0);
      send(8'hAA, 0, 1);
      chk("zc_errs1", num_errors, 32'd1);
      chk("zc_fei", 32'(first_err_idx), 32'd0);
   endtask

   task automatic test_overflow();
      do_start(2);
      send(8'h11, 0, 0);
      send(8'h22, 0, 1);
      chk("ov_done", 32'(done), 32'd1);
      chk("ov_errs0", num_errors, 32'd0);
      send(8'h55, 1, 1);
      chk("ov_errs1", num_errors, 32'd1);
      chk("ov_fei", 32'(first_err_idx), 32'd2);
   endtask

   task automatic test_reset_mid();
      do_start(3);
      send(8'h11, 0, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rm_done", 32'(done), 32'd0);
      chk("rm_rdy", 32'(sink.in_rdy), 32'd0);
      chk("rm_errs", num_errors, 32'd0);
      do_start(3);
      send(8'h11, 0, 0);
      send(8'h22, 0, 0);
      send(8'h33, 0, 1);
      chk("rm_done2", 32'(done), 32'd1);
      chk("rm_errs2", num_errors, 32'd0);
   endtask

   task automatic test_run_ignores();
      do_start(3);
      send(8'h11, 0, 1);
      ld_en = 1'b1; ld_addr = 1; ld_msg = 8'h99;
      num_msgs = 1; start = 1'b1;
      step();
      ld_en = 1'b0; start = 1'b0;
      send(8'h22, 0, 1);
      chk("ri_done2", 32'(done), 32'd0);
      send(8'h33, 0, 1);
      chk("ri_done3", 32'(done), 32'd1);
      chk("ri_errs", num_errors, 32'd0);
   endtask

   task automatic test_load_and_start();
      ld_en = 1'b1; ld_addr = 0; ld_msg = 8'h44;
      num_msgs = 1; start = 1'b1;
      step();
      ld_en = 1'b0; start = 1'b0;
      chk("ls_done0", 32'(done), 32'd0);
      send(8'h44, 0, 1);
      chk("ls_done1", 32'(done), 32'd1);
      chk("ls_errs", num_errors, 32'd0);
   endtask

   task automatic test_clamp();
      for (int i = 0; i < NM; i++) load(IW'(i), 8'(i) ^ 8'h5A);
      do_start(11'h7FF);
      for (int i = 0; i < NM - 1; i++) send(8'(i) ^ 8'h5A, 0, 0);
      sink.in_val = 1'b0;
      chk("cl_done_pre", 32'(done), 32'd0);
      send(8'(NM - 1) ^ 8'h5A, 0, 1);
      chk("cl_done", 32'(done), 32'd1);
      chk("cl_errs0", num_errors, 32'd0);
      send(8'h00, 0, 1);
      chk("cl_errs1", num_errors, 32'd1);
      chk("cl_fei", 32'(first_err_idx), 32'd1024);
   endtask

`ifdef VC_TEST_SINK_CHECKER_MASK_EN
   task automatic test_mask();
      ld_mask = 8'h0F;
      load(0, 8'hA5);
      ld_mask = 8'h00;
      do_start(1);
      send(8'hA3, 0, 1);
      chk("mk_errs0", num_errors, 32'd0);
      do_start(1);
      send(8'hB5, 0, 1);
      chk("mk_errs1", num_errors, 32'd1);
      chk("mk_fei", 32'(first_err_idx), 32'd0);
   endtask
`endif

   initial begin
      reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_msg = '0;
`ifdef VC_TEST_SINK_CHECKER_MASK_EN
      ld_mask = '0;
`endif
      num_msgs = '0; start = 1'b0;
      sink.in_val = 1'b0; sink.in_msg = '0;
      test_reset();
      test_back_to_back();
      test_mismatch_delay();
      test_zero_count();
      test_overflow();
      test_reset_mid();
      test_run_ignores();
      test_load_and_start();
`ifdef VC_TEST_SINK_CHECKER_MASK_EN
      test_mask();
`endif
      test_clamp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
